// File: rtl/sram_like_responder_pkg.sv
// Shared encodings and helpers for the SRAM-like bus.
// Used by initiators and by the responder itself.
package sram_like_responder_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int DEPTH = 2;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic             vld;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      data;
  } q_entry_t;

  function automatic logic [3:0] byte_en(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [3:0] be;
    unique case (1'b1)
      (size == SIZE_BYTE): be = 4'b0001 << lo;
      (size == SIZE_HALF): be = lo[1] ? 4'b1100 : 4'b0011;
      default:             be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sram_like_resp_queue.sv
// In-order response queue: each entry ages a latency counter.
// Head pops once its counter has reached zero.
module sram_like_resp_queue #(
  parameter int N       = sram_like_responder_pkg::DEPTH,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic [31:0] push_data_i,
  output logic        full_o,
  output logic        pop_o,
  output logic [31:0] pop_data_o
);
  import sram_like_responder_pkg::*;

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(LATENCY - 1);

  q_entry_t ent_q [N];
  q_entry_t ent_d [N];
  q_entry_t aged  [N];
  logic     placed;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      aged[i] = ent_q[i];
      if (ent_q[i].vld && ent_q[i].cnt != '0)
        aged[i].cnt = ent_q[i].cnt - CNT_W'(1);
    end
    pop_o = ent_q[0].vld && (ent_q[0].cnt == '0);
    for (int i = 0; i < N - 1; i++)
      ent_d[i] = pop_o ? aged[i+1] : aged[i];
    ent_d[N-1] = pop_o ? '0 : aged[N-1];
    // new entry lands in the first free slot behind the shift
    placed = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (push_i && !placed && !ent_d[i].vld) begin
        ent_d[i] = '{vld: 1'b1, cnt: LOAD,
                     data: push_data_i};
        placed = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        ent_q[i] <= ent_d[i];
    end
  end

  assign full_o     = ent_q[N-1].vld;
  assign pop_data_o = ent_q[0].data;

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like slave: word array with lane writes and
// fixed-latency, in-order responses.
module sram_like_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1,
  parameter int DEPTH      = sram_like_responder_pkg::DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  import sram_like_responder_pkg::*;

  localparam int WORDS = 1 << ADDR_WIDTH;

  logic [31:0]           mem_q [WORDS];
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            be;
  logic [31:0]           cur_w;
  logic [31:0]           upd_w;
  logic                  acc;
  logic                  full;
  logic                  pop;
  logic [31:0]           pop_data;
  logic                  data_ok_q;
  logic [31:0]           rdata_q;
  logic [31:0]           rdata_d;
  logic                  unused_addr;

  assign idx   = addr[ADDR_WIDTH+1:2];
  assign be    = wr ? byte_en(size, addr[1:0]) : 4'b0000;
  assign cur_w = mem_q[idx];
  assign upd_w = lane_merge(cur_w, wdata, be);

  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  // addr_ok depends only on stored occupancy, never on a pop
  assign addr_ok = rst & ~full;
  assign acc     = req & addr_ok;

  always_ff @(posedge clk) begin
    if (acc && wr)
      mem_q[idx] <= upd_w;
  end

  sram_like_resp_queue #(
    .N       (DEPTH),
    .LATENCY (LATENCY)
  ) u_q (
    .clk         (clk),
    .rst_n       (rst),
    .push_i      (acc),
    .push_data_i (upd_w),
    .full_o      (full),
    .pop_o       (pop),
    .pop_data_o  (pop_data)
  );

  assign rdata_d = pop ? pop_data : rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      data_ok_q <= pop;
      rdata_q   <= rdata_d;
    end
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;

endmodule
